// File: rtl/mul4_ctrl_pkg.sv
// Shared types and constants for the 4x4 shift-add multiplier sequencer.
package mul4_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int                STEP_W    = 2;
  localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

  // Datapath select/enable bundle driven during each partial-product step.
  typedef struct packed {
    logic s0;
    logic s1;
    logic s2;
    logic acc_clr;
  } sel_t;

endpackage

// File: rtl/mul4_step_decode.sv
// Combinational decode of the step counter into the datapath select bundle
// (Horner order: aH*bH, aH*bL, aL*bH, aL*bL).
module mul4_step_decode
  import mul4_ctrl_pkg::*;
(
  input  logic [1:0] k,
  output logic [3:0] sel
);

  sel_t dec;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    dec = '0;
    unique case (k)
      2'd0: begin dec.s0 = 1'b1; dec.s1 = 1'b1; dec.acc_clr = 1'b1; end
      2'd1: begin dec.s0 = 1'b1; dec.s2 = 1'b1; end
      2'd2: begin dec.s1 = 1'b1; end
      2'd3: begin dec.s2 = 1'b1; end
      default: dec = '0;
    endcase
  end

  assign sel = dec;

endmodule

// File: rtl/mul4_controller.sv
// Sequencing FSM for the 4x4 shift-add multiplier datapath.
// Optional MUL4_CTRL_DONE_HOLD_EN: DONE is held until ack is sampled high.
module mul4_controller
  import mul4_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic ld,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic acc_clr,
  output logic acc_en,
  output logic busy,
  output logic done
);

  state_t            state, state_next;
  logic [STEP_W-1:0] k, k_next;
  logic [3:0]        step_sel;
  sel_t              sel;

  mul4_step_decode u_step_decode (
    .k   (k),
    .sel (step_sel)
  );

  assign sel = step_sel;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  always_comb begin
    state_next = state;
    k_next     = '0;
    unique case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = STEP;
      STEP: begin
        if (k == LAST_STEP) begin
          state_next = DONE;
        end else begin
          k_next = k + 2'd1;
        end
      end
      DONE: begin
`ifdef MUL4_CTRL_DONE_HOLD_EN
        if (ack) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

`ifndef MUL4_CTRL_DONE_HOLD_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif

  // Moore outputs: decoded only from registered state and k.
  always_comb begin
    ld      = 1'b0;
    s0      = 1'b0;
    s1      = 1'b0;
    s2      = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        ld   = 1'b1;
        busy = 1'b1;
      end
      STEP: begin
        s0      = sel.s0;
        s1      = sel.s1;
        s2      = sel.s2;
        acc_clr = sel.acc_clr;
        acc_en  = 1'b1;
        busy    = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mul4_controller.md
# mul4_controller

Sequencing FSM for the 4x4 shift-add multiplier datapath. It sits directly upstream of the datapath: it accepts a start request, drives the operand load, the three select lines (s0, s1, s2) and the accumulator enable/clear, and signals completion. One multiply takes four 2x2 partial-product steps in Horner order: acc = aH·bH; acc = (acc<<2)+aH·bL; acc = acc+aL·bH; acc = (acc<<2)+aL·bL.

## Interface
- No parameters.
- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- ack  input  1  completion acknowledge; used only when MUL4_CTRL_DONE_HOLD_EN is defined.
- ld  output  1  operand registers load a, b.
- s0  output  1  1 = high half of a to the 2x2 multiplier, 0 = low half.
- s1  output  1  1 = high half of b, 0 = low half.
- s2  output  1  1 = accumulator feedback via shift-left-2, 0 = unshifted.
- acc_clr  output  1  accumulator feedback forced to zero this cycle.
- acc_en  output  1  accumulator register captures the adder result.
- busy  output  1  high from LOAD through the last step.
- done  output  1  product valid on the datapath output.

## Operation
- States: IDLE, LOAD, STEP, DONE. 2-bit step counter k, active only in STEP.
- IDLE: all outputs 0. start=1 -> LOAD.
- LOAD: ld=1, busy=1, acc_en=0. Always -> STEP with k=0.
- STEP (busy=1, acc_en=1), select set per k:
  - k=0: s0=1 s1=1 s2=0 acc_clr=1.
  - k=1: s0=1 s1=0 s2=1.
  - k=2: s0=0 s1=1 s2=0.
  - k=3: s0=0 s1=0 s2=1; -> DONE.
  - k increments modulo 4; no wrap occurs because k=3 always exits.
- DONE: done=1, acc_en=0 (product held), busy=0. Exit rule per Configuration.
- start outside IDLE is ignored and not queued.
- ack outside DONE is ignored.
- Reset (rst=0) at any point: next state IDLE, k=0, all outputs 0 the following cycle; an in-flight multiply is abandoned.
- Outputs are Moore (decoded from registered state and k only). No combinational path from start or ack to any output.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycle 1: LOAD.
- Cycles 2–5: STEP k=0..3.
- Cycle 6: DONE; the product is valid on the datapath output from this cycle.
- Start-to-done latency: 6 cycles.
- With the one-cycle done pulse, a start at cycle 7 begins the next multiply, giving a throughput of 1 multiply per 7 cycles.
- Reset values: ld=s0=s1=s2=acc_clr=acc_en=busy=done=0.

## Configuration
- MUL4_CTRL_DONE_HOLD_EN:
  - Defined: DONE persists with done=1 until ack=1 is sampled, then -> IDLE. start during DONE is ignored.
  - Undefined: DONE lasts exactly one cycle and always -> IDLE. ack is unused.

## Structure
- Package mul4_ctrl_pkg holds:
  - state enum (IDLE, LOAD, STEP, DONE);
  - step-count width constant (2) and last-step constant (3);
  - packed struct for the select/enable bundle {s0, s1, s2, acc_clr}.
- Sub-module mul4_step_decode: combinational decode of k into the select bundle. Instantiated once; the FSM top registers state and k.

## Test plan
- Reset: rst=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, no ld pulse.
- Basic multiply: start pulse, a=4'hB, b=4'hD, driving the real datapath -> ld at cycle 1; select sequence (s0,s1,s2) = 110,101,010,001 at cycles 2–5; acc = 6, 26, 35, 143; done at cycle 6 with out=8'h8F.
- Corner operands: a=b=4'hF -> out=8'hE1 (225); a=0, b=4'h9 -> out=8'h00.
- Ignored start: start held high throughout -> exactly one ld per multiply, with a 7-cycle spacing between ld pulses (pulse mode).
- Mid-operation reset: rst=0 at cycle 3 (STEP k=1) -> IDLE next cycle, done never asserts; a fresh start then completes normally in 6 cycles.
- Hold mode (macro defined): ack withheld 5 cycles -> done stays 1 and the product is stable; ack=1 -> IDLE next cycle; start asserted during DONE has no effect.
